// File: rtl/alu_link_master_if.sv
// UART-side byte link between the ALU link master and a uart instance.
// The master drives the transmit byte and strobe and observes busy and RX.
interface alu_link_master_if;
   logic [7:0] TXbuffer;
   logic       TXstart;
   logic       TXbusy;
   logic [7:0] RXbuffer;
   logic       RXready;

   modport master (
      output TXbuffer,
      output TXstart,
      input  TXbusy,
      input  RXbuffer,
      input  RXready
   );

   modport slave (
      input  TXbuffer,
      input  TXstart,
      output TXbusy,
      output RXbuffer,
      output RXready
   );
endinterface

// File: rtl/alu_link_master.sv
// Host-side ALU link initiator: sends a 9-byte command over the UART,
// then collects the 3-byte response and reports done or timeout.
module alu_link_master #(
   parameter int TIMEOUT_CYCLES = 1200000
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        start,
   input  logic [5:0]  operation,
   input  logic [3:0]  params,
   input  logic [2:0]  opA,
   input  logic [2:0]  opB,
   input  logic [2:0]  opY,
   input  logic [15:0] operand0,
   input  logic [15:0] operand1,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [15:0] result,
   output logic        overflow,
   alu_link_master_if.master link
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, SEND, WAIT_HI, WAIT_LO, RESP
   } state_t;

   state_t state, state_n;

   logic [3:0]    idx, idx_n;
   logic [1:0]    rx_idx, rx_idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [5:0]    op_q, op_n;
   logic [3:0]    par_q, par_n;
   logic [2:0]    a_q, a_n;
   logic [2:0]    b_q, b_n;
   logic [2:0]    y_q, y_n;
   logic [15:0]   o0_q, o0_n;
   logic [15:0]   o1_q, o1_n;
   logic [7:0]    lo_q, lo_n;
   logic [7:0]    hi_q, hi_n;
   logic          busy_n, done_n, timeout_n;
   logic [15:0]   result_n;
   logic          overflow_n;
   logic [7:0]    tx_buf, tx_buf_n;
   logic          tx_start, tx_start_n;
   logic [7:0]    tx_byte;
   logic          expired;
   logic          abort;
   logic          unused_rx;

   assign unused_rx     = ^link.RXbuffer[7:1];
   assign link.TXbuffer = tx_buf;
   assign link.TXstart  = tx_start;
   assign expired       = (cnt == LIMIT);

   always_comb begin
      case (idx)
         4'd0:    tx_byte = {2'b00, op_q};
         4'd1:    tx_byte = {4'h0, par_q};
         4'd2:    tx_byte = {5'b0, a_q};
         4'd3:    tx_byte = {5'b0, b_q};
         4'd4:    tx_byte = {5'b0, y_q};
         4'd5:    tx_byte = o0_q[7:0];
         4'd6:    tx_byte = o0_q[15:8];
         4'd7:    tx_byte = o1_q[7:0];
         default: tx_byte = o1_q[15:8];
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         idx      <= '0;
         rx_idx   <= '0;
         cnt      <= '0;
         op_q     <= '0;
         par_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         y_q      <= '0;
         o0_q     <= '0;
         o1_q     <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         timeout  <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
         tx_buf   <= '0;
         tx_start <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         rx_idx   <= rx_idx_n;
         cnt      <= cnt_n;
         op_q     <= op_n;
         par_q    <= par_n;
         a_q      <= a_n;
         b_q      <= b_n;
         y_q      <= y_n;
         o0_q     <= o0_n;
         o1_q     <= o1_n;
         lo_q     <= lo_n;
         hi_q     <= hi_n;
         busy     <= busy_n;
         done     <= done_n;
         timeout  <= timeout_n;
         result   <= result_n;
         overflow <= overflow_n;
         tx_buf   <= tx_buf_n;
         tx_start <= tx_start_n;
      end
   end

   // An RXready in the expiry cycle wins over the timeout.
   always_comb begin
      state_n = state;
      abort   = 1'b0;
      unique case (state)
         IDLE:
            if (start) state_n = SEND;
         SEND:
            if (!link.TXbusy) state_n = WAIT_HI;
         WAIT_HI: begin
            abort = expired && !link.TXbusy;
            if (link.TXbusy) state_n = WAIT_LO;
            else if (abort) state_n = IDLE;
         end
         WAIT_LO: begin
            abort = expired && link.TXbusy;
            if (!link.TXbusy) state_n = (idx == 4'd8) ? RESP : SEND;
            else if (abort) state_n = IDLE;
         end
         RESP: begin
            abort = expired && !link.RXready;
            if (link.RXready && rx_idx == 2'd2) state_n = IDLE;
            else if (abort) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      idx_n      = idx;
      rx_idx_n   = rx_idx;
      op_n       = op_q;
      par_n      = par_q;
      a_n        = a_q;
      b_n        = b_q;
      y_n        = y_q;
      o0_n       = o0_q;
      o1_n       = o1_q;
      lo_n       = lo_q;
      hi_n       = hi_q;
      busy_n     = busy;
      done_n     = 1'b0;
      timeout_n  = 1'b0;
      result_n   = result;
      overflow_n = overflow;
      tx_buf_n   = tx_buf;
      tx_start_n = 1'b0;
      unique case (state)
         IDLE:
            if (start) begin
               op_n     = operation;
               par_n    = params;
               a_n      = opA;
               b_n      = opB;
               y_n      = opY;
               o0_n     = operand0;
               o1_n     = operand1;
               busy_n   = 1'b1;
               idx_n    = '0;
               rx_idx_n = '0;
            end
         SEND:
            if (!link.TXbusy) begin
               tx_buf_n   = tx_byte;
               tx_start_n = 1'b1;
            end
         WAIT_HI: ;
         WAIT_LO:
            if (!link.TXbusy && idx != 4'd8) idx_n = idx + 4'd1;
         RESP:
            if (link.RXready) begin
               unique case (rx_idx)
                  2'd0: begin
                     lo_n     = link.RXbuffer;
                     rx_idx_n = 2'd1;
                  end
                  2'd1: begin
                     hi_n     = link.RXbuffer;
                     rx_idx_n = 2'd2;
                  end
                  default: begin
                     result_n   = {hi_q, lo_q};
                     overflow_n = link.RXbuffer[0];
                     done_n     = 1'b1;
                     busy_n     = 1'b0;
                     rx_idx_n   = '0;
                  end
               endcase
            end
         default: ;
      endcase
      if (abort) begin
         timeout_n = 1'b1;
         busy_n    = 1'b0;
         rx_idx_n  = '0;
      end
   end

   // Idle counter only runs while waiting on the UART or a response byte.
   always_comb begin
      cnt_n = cnt;
      if (state_n != state)
         cnt_n = '0;
      else if (state == RESP && link.RXready)
         cnt_n = '0;
      else if (state == WAIT_HI || state == WAIT_LO || state == RESP)
         cnt_n = cnt + CW'(1);
   end

endmodule

// File: tb/tb_alu_link_master.sv
// Directed bench for alu_link_master with a behavioural UART model
// that stays busy for 10 cycles after each launch.
module tb_alu_link_master;
   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        start;
   logic [5:0]  operation;
   logic [3:0]  params;
   logic [2:0]  opA, opB, opY;
   logic [15:0] operand0, operand1;
   logic        busy, done, timeout, overflow;
   logic [15:0] result;

   int ncmp = 0;
   int nerr = 0;

   always #5 CLK = ~CLK;

   alu_link_master_if u_if ();

   alu_link_master #(.TIMEOUT_CYCLES(100)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .start     (start),
      .operation (operation),
      .params    (params),
      .opA       (opA),
      .opB       (opB),
      .opY       (opY),
      .operand0  (operand0),
      .operand1  (operand1),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout),
      .result    (result),
      .overflow  (overflow),
      .link      (u_if)
   );

   int        cyc = 0;
   logic [7:0] txq[$];
   int        bcnt = 0;
   bit        hold = 1'b0;
   int        last_fall = 0;
   int        long_pulses = 0;
   int        tmo_seen = 0;
   bit        prev_txs = 1'b0;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (u_if.TXstart === 1'b1) begin
         txq.push_back(u_if.TXbuffer);
         if (prev_txs) long_pulses++;
         bcnt = 10;
      end else if (bcnt > 0) begin
         bcnt--;
         if (bcnt == 0) last_fall = cyc;
      end
      prev_txs = (u_if.TXstart === 1'b1);
      u_if.TXbusy = hold || (bcnt != 0);
      if (timeout === 1'b1) tmo_seen++;
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(logic [5:0] op, logic [3:0] par, logic [2:0] a,
                     logic [2:0] b, logic [2:0] y,
                     logic [15:0] o0, logic [15:0] o1);
      @(negedge CLK);
      operation = op; params = par;
      opA = a; opB = b; opY = y;
      operand0 = o0; operand1 = o1;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      operation = ~op; params = ~par;
      opA = ~a; opB = ~b; opY = ~y;
      operand0 = ~o0; operand1 = ~o1;
   endtask

   task automatic wait_tx(int n);
      int k = 0;
      while (txq.size() < n && k < 3000) begin
         @(negedge CLK);
         k++;
      end
   endtask

   task automatic wait_frame();
      wait_tx(9);
      repeat (14) @(negedge CLK);
      chk("frame_len", 32'(txq.size()), 32'd9);
   endtask

   task automatic check_frame(string tag, logic [71:0] exp);
      logic [7:0] got;
      for (int i = 0; i < 9; i++) begin
         got = (i < txq.size()) ? txq[i] : 8'hxx;
         chk($sformatf("%s_b%0d", tag, i), 32'(got),
             32'(exp[71-8*i -: 8]));
      end
      txq.delete();
   endtask

   task automatic rx(logic [7:0] b);
      @(negedge CLK);
      u_if.RXbuffer = b;
      u_if.RXready  = 1'b1;
      @(negedge CLK);
      u_if.RXready  = 1'b0;
   endtask

   task automatic respond(string tag, logic [7:0] b0, logic [7:0] b1,
                          logic [7:0] b2, logic [15:0] prev,
                          logic [15:0] res, logic ovf);
      rx(b0);
      rx(b1);
      chk({tag, "_shadow"}, 32'(result), 32'(prev));
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      rx(b2);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_result"}, 32'(result), 32'(res));
      chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
      @(negedge CLK);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int k;
      start = 1'b0;
      operation = '0; params = '0;
      opA = '0; opB = '0; opY = '0;
      operand0 = '0; operand1 = '0;
      u_if.RXready = 1'b0;
      u_if.RXbuffer = '0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_txstart", 32'(u_if.TXstart), 32'd0);
      chk("rst_txbuf", 32'(u_if.TXbuffer), 32'd0);
      RESET_N = 1'b1;
      @(negedge CLK);

      // normal transaction, with launch latency
      go(6'h01, 4'h0, 3'd0, 3'd1, 3'd0, 16'h1234, 16'h0001);
      @(negedge CLK);
      chk("launch_txstart", 32'(u_if.TXstart), 32'd1);
      chk("launch_txbuf", 32'(u_if.TXbuffer), 32'h01);
      wait_frame();
      check_frame("norm", 72'h01_00_00_01_00_34_12_01_00);
      respond("norm", 8'h35, 8'h12, 8'h00, 16'h0000, 16'h1235, 1'b0);

      // overflow byte, upper bits ignored
      go(6'h3F, 4'hA, 3'd7, 3'd5, 3'd2, 16'hABCD, 16'h0102);
      wait_frame();
      check_frame("ovf", 72'h3F_0A_07_05_02_CD_AB_02_01);
      respond("ovf", 8'hFF, 8'hFF, 8'h03, 16'h1235, 16'hFFFF, 1'b1);

      // response timeout
      go(6'h02, 4'h1, 3'd1, 3'd2, 3'd3, 16'h0000, 16'hFFFF);
      wait_frame();
      check_frame("tmo", 72'h02_01_01_02_03_00_00_FF_FF);
      k = 0;
      while (timeout !== 1'b1 && k < 300) begin
         @(negedge CLK);
         k++;
      end
      chk("tmo_pulse", 32'(timeout), 32'd1);
      chk("tmo_latency", 32'(cyc - last_fall), 32'd101);
      chk("tmo_busy", 32'(busy), 32'd0);
      chk("tmo_nodone", 32'(done), 32'd0);
      chk("tmo_result", 32'(result), 32'hFFFF);
      chk("tmo_ovf", 32'(overflow), 32'd1);
      @(negedge CLK);
      chk("tmo_single", 32'(timeout), 32'd0);
      go(6'h04, 4'hF, 3'd3, 3'd4, 3'd5, 16'h8000, 16'h7FFF);
      wait_frame();
      check_frame("retry", 72'h04_0F_03_04_05_00_80_FF_7F);
      respond("retry", 8'h00, 8'h80, 8'hFE, 16'hFFFF, 16'h8000, 1'b0);

      // start and RXready during the send phase are ignored
      go(6'h05, 4'h2, 3'd6, 3'd7, 3'd1, 16'h5555, 16'hAAAA);
      wait_tx(4);
      @(negedge CLK);
      operation = 6'h2A;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      rx(8'hAA);
      wait_frame();
      check_frame("ign", 72'h05_02_06_07_01_55_55_AA_AA);
      respond("ign", 8'h11, 8'h22, 8'h01, 16'h8000, 16'h2211, 1'b1);

      // UART held busy longer than the timeout at start
      hold = 1'b1;
      repeat (2) @(negedge CLK);
      go(6'h10, 4'h3, 3'd2, 3'd2, 3'd2, 16'h0102, 16'h0304);
      repeat (150) @(negedge CLK);
      chk("hold_no_tx", 32'(txq.size()), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      hold = 1'b0;
      wait_frame();
      check_frame("hold", 72'h10_03_02_02_02_02_01_04_03);
      respond("hold", 8'h01, 8'h00, 8'h00, 16'h2211, 16'h0001, 1'b0);
      chk("hold_no_tmo", 32'(tmo_seen), 32'd1);

      // reset during byte 4
      go(6'h07, 4'h0, 3'd1, 3'd1, 3'd6, 16'h9999, 16'h8888);
      wait_tx(5);
      @(negedge CLK);
      #2 RESET_N = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_txbuf", 32'(u_if.TXbuffer), 32'd0);
      chk("arst_txstart", 32'(u_if.TXstart), 32'd0);
      chk("arst_result", 32'(result), 32'd0);
      chk("arst_ovf", 32'(overflow), 32'd0);
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      txq.delete();
      go(6'h08, 4'h4, 3'd0, 3'd7, 3'd3, 16'hCAFE, 16'hBEEF);
      wait_frame();
      check_frame("post_rst", 72'h08_04_00_07_03_FE_CA_EF_BE);
      respond("post_rst", 8'h34, 8'h12, 8'h01, 16'h0000, 16'h1234, 1'b1);

      chk("txstart_width", 32'(long_pulses), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
